// File: rtl/sig16b_conv_sched.sv
// Shares one sig16b_to_double converter between the mic (ch0) and reference (ch1) streams.
// Define OVR_COUNT_EN to add saturating per-channel overrun counters (mic_ovr_cnt, ref_ovr_cnt).
module sig16b_conv_sched #(
    parameter int unsigned TIMEOUT = 63,
    parameter int unsigned TO_W    = 6
) (
    input  logic        clk_operation,
    input  logic        rst_n,
    input  logic [15:0] mic_sample,
    input  logic        mic_valid,
    input  logic [15:0] ref_sample,
    input  logic        ref_valid,
    output logic        mic_overrun,
    output logic        ref_overrun,
`ifdef OVR_COUNT_EN
    output logic [7:0]  mic_ovr_cnt,
    output logic [7:0]  ref_ovr_cnt,
`endif
    output logic [15:0] cvt_sig16b,
    output logic        cvt_enable,
    input  logic [63:0] cvt_double,
    input  logic        cvt_ready,
    output logic [63:0] out_double,
    output logic        out_ch,
    output logic        out_valid,
    input  logic        out_ack,
    output logic        timeout_err
);

    typedef enum logic [2:0] {StIdle, StIssue, StArm, StWait, StHold} state_e;

    state_e            state_q, state_d;
    logic              grant_q, grant_d;
    logic              last_q, last_d;
    logic [TO_W-1:0]   cnt_q, cnt_d;
    logic [15:0]       buf_mic_q, buf_ref_q;
    logic              full_mic_q, full_ref_q;
    logic              mic_ovr_q, ref_ovr_q;
    logic [15:0]       cvt_last_q;
    logic [63:0]       out_double_q;
    logic              out_ch_q;
    logic              take_mic, take_ref, capture;
    logic [15:0]       buf_g;

    assign buf_g = grant_q ? buf_ref_q : buf_mic_q;

    always_comb begin
        state_d     = state_q;
        grant_d     = grant_q;
        last_d      = last_q;
        cnt_d       = cnt_q;
        take_mic    = 1'b0;
        take_ref    = 1'b0;
        capture     = 1'b0;
        cvt_enable  = 1'b0;
        timeout_err = 1'b0;
        out_valid   = 1'b0;
        case (state_q)
            StIdle: begin
                if (full_mic_q || full_ref_q) begin
                    // On a tie the channel not served last wins.
                    grant_d = (full_mic_q && full_ref_q) ? ~last_q : full_ref_q;
                    state_d = StIssue;
                end
            end
            StIssue: begin
                cvt_enable = 1'b1;
                take_mic   = ~grant_q;
                take_ref   = grant_q;
                last_d     = grant_q;
                state_d    = StArm;
            end
            StArm: begin
                // cvt_ready may still be high from the previous conversion here.
                cnt_d   = '0;
                state_d = StWait;
            end
            StWait: begin
                if (cvt_ready) begin
                    capture = 1'b1;
                    state_d = StHold;
                end else if (cnt_q == TO_W'(TIMEOUT)) begin
                    timeout_err = 1'b1;
                    state_d     = StIdle;
                end else begin
                    cnt_d = cnt_q + TO_W'(1);
                end
            end
            StHold: begin
                out_valid = 1'b1;
                if (out_ack) state_d = StIdle;
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk_operation) begin
        if (!rst_n) begin
            state_q      <= StIdle;
            grant_q      <= 1'b0;
            last_q       <= 1'b1;
            cnt_q        <= '0;
            buf_mic_q    <= '0;
            buf_ref_q    <= '0;
            full_mic_q   <= 1'b0;
            full_ref_q   <= 1'b0;
            mic_ovr_q    <= 1'b0;
            ref_ovr_q    <= 1'b0;
            cvt_last_q   <= '0;
            out_double_q <= '0;
            out_ch_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            grant_q    <= grant_d;
            last_q     <= last_d;
            cnt_q      <= cnt_d;
            if (mic_valid) buf_mic_q <= mic_sample;
            if (ref_valid) buf_ref_q <= ref_sample;
            full_mic_q <= mic_valid | (full_mic_q & ~take_mic);
            full_ref_q <= ref_valid | (full_ref_q & ~take_ref);
            mic_ovr_q  <= mic_valid & full_mic_q & ~take_mic;
            ref_ovr_q  <= ref_valid & full_ref_q & ~take_ref;
            if (cvt_enable) cvt_last_q <= buf_g;
            if (capture) begin
                out_double_q <= cvt_double;
                out_ch_q     <= grant_q;
            end
        end
    end

    assign cvt_sig16b  = (state_q == StIssue) ? buf_g : cvt_last_q;
    assign out_double  = out_double_q;
    assign out_ch      = out_ch_q;
    assign mic_overrun = mic_ovr_q;
    assign ref_overrun = ref_ovr_q;

`ifdef OVR_COUNT_EN
    logic [7:0] mic_cnt_q, ref_cnt_q;

    always_ff @(posedge clk_operation) begin
        if (!rst_n) begin
            mic_cnt_q <= '0;
            ref_cnt_q <= '0;
        end else begin
            if (mic_ovr_q && mic_cnt_q != 8'hFF) mic_cnt_q <= mic_cnt_q + 8'd1;
            if (ref_ovr_q && ref_cnt_q != 8'hFF) ref_cnt_q <= ref_cnt_q + 8'd1;
        end
    end

    assign mic_ovr_cnt = mic_cnt_q;
    assign ref_ovr_cnt = ref_cnt_q;
`endif

endmodule

// File: tb/tb_sig16b_conv_sched.sv
// Bench for sig16b_conv_sched: converter model, result scoreboard, table vectors, corner sequences.
module tb_sig16b_conv_sched;

    localparam int unsigned TIMEOUT = 63;
    localparam int unsigned TO_W    = 6;
    localparam int          LAT     = 4;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [15:0] mic_sample, ref_sample;
    logic        mic_valid, ref_valid;
    logic        mic_overrun, ref_overrun;
    logic [15:0] cvt_sig16b;
    logic        cvt_enable;
    logic [63:0] cvt_double = '0;
    logic        cvt_ready = 1'b0;
    logic [63:0] out_double;
    logic        out_ch, out_valid;
    logic        out_ack = 1'b0;
    logic        timeout_err;
`ifdef OVR_COUNT_EN
    logic [7:0]  mic_ovr_cnt, ref_ovr_cnt;
`endif

    always #5 clk = ~clk;

    sig16b_conv_sched #(.TIMEOUT(TIMEOUT), .TO_W(TO_W)) dut (
        .clk_operation (clk),
        .rst_n         (rst_n),
        .mic_sample    (mic_sample),
        .mic_valid     (mic_valid),
        .ref_sample    (ref_sample),
        .ref_valid     (ref_valid),
        .mic_overrun   (mic_overrun),
        .ref_overrun   (ref_overrun),
`ifdef OVR_COUNT_EN
        .mic_ovr_cnt   (mic_ovr_cnt),
        .ref_ovr_cnt   (ref_ovr_cnt),
`endif
        .cvt_sig16b    (cvt_sig16b),
        .cvt_enable    (cvt_enable),
        .cvt_double    (cvt_double),
        .cvt_ready     (cvt_ready),
        .out_double    (out_double),
        .out_ch        (out_ch),
        .out_valid     (out_valid),
        .out_ack       (out_ack),
        .timeout_err   (timeout_err)
    );

    typedef struct packed {
        logic        ch;
        logic [63:0] d;
    } res_t;

    typedef struct {
        logic        ch;
        logic [15:0] smp;
        logic [63:0] dbl;
    } vec_t;

    res_t sb_q[$];
    res_t mon_e;
    vec_t vecs[6];
    int   n_checks = 0;
    int   n_err = 0;
    int   mic_pulses = 0;
    int   ref_pulses = 0;
    bit   ack_en = 1'b1;
    bit   stuck = 1'b0;
    bit   stale = 1'b0;

    // Sign-magnitude sample to double; the converter scales the magnitude by 2.
    function automatic logic [63:0] conv(input logic [15:0] s);
        logic [14:0] m;
        logic [51:0] f;
        int          p;
        m = s[14:0];
        if (m == 15'd0) return {s[15], 63'd0};
        p = 0;
        for (int i = 0; i < 15; i++) if (m[i]) p = i;
        f = 52'(m) << (52 - p);
        return {s[15], 11'(1024 + p), f};
    endfunction

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h, required %h", name, act, exp);
        end
    endtask

    // Converter model: result LAT cycles after enable; ready is a level.
    bit          m_busy = 1'b0;
    int          m_cnt = 0;
    logic [15:0] m_smp = '0;
    always @(posedge clk) begin
        if (cvt_enable) begin
            m_busy <= 1'b1;
            m_cnt  <= 0;
            m_smp  <= cvt_sig16b;
            if (!stale) cvt_ready <= 1'b0;
        end else if (m_busy) begin
            m_cnt <= m_cnt + 1;
            if (m_cnt == 0) cvt_ready <= 1'b0;
            if (m_cnt == LAT && !stuck) begin
                cvt_ready  <= 1'b1;
                cvt_double <= conv(m_smp);
                m_busy     <= 1'b0;
            end
        end
    end

    always @(negedge clk) begin
        if (mic_overrun) mic_pulses++;
        if (ref_overrun) ref_pulses++;
    end

    always @(negedge clk) begin
        if (rst_n === 1'b1 && out_valid && !out_ack && ack_en) begin
            if (sb_q.size() == 0) begin
                n_checks++;
                n_err++;
                $display("FAIL unexpected_result: got ch=%0d %h, required no result", out_ch,
                         out_double);
            end else begin
                mon_e = sb_q.pop_front();
                chk("result_ch", 64'(out_ch), 64'(mon_e.ch));
                chk("result_double", out_double, mon_e.d);
            end
            out_ack = 1'b1;
        end else begin
            out_ack = 1'b0;
        end
    end

    task automatic send(input logic ch, input logic [15:0] s, input bit expect_it);
        @(negedge clk);
        if (ch) begin
            ref_sample = s;
            ref_valid  = 1'b1;
        end else begin
            mic_sample = s;
            mic_valid  = 1'b1;
        end
        if (expect_it) sb_q.push_back(res_t'{ch, conv(s)});
        @(negedge clk);
        mic_valid = 1'b0;
        ref_valid = 1'b0;
    endtask

    task automatic send_both(input logic [15:0] m, input logic [15:0] r, input bit ref_first);
        @(negedge clk);
        mic_sample = m;
        ref_sample = r;
        mic_valid  = 1'b1;
        ref_valid  = 1'b1;
        if (ref_first) begin
            sb_q.push_back(res_t'{1'b1, conv(r)});
            sb_q.push_back(res_t'{1'b0, conv(m)});
        end else begin
            sb_q.push_back(res_t'{1'b0, conv(m)});
            sb_q.push_back(res_t'{1'b1, conv(r)});
        end
        @(negedge clk);
        mic_valid = 1'b0;
        ref_valid = 1'b0;
    endtask

    task automatic wait_valid(input string name);
        int i = 0;
        while (!out_valid && i < 200) begin
            @(negedge clk);
            i++;
        end
        chk(name, 64'(out_valid), 64'd1);
    endtask

    task automatic drain(input string name);
        int i = 0;
        while ((sb_q.size() != 0 || out_valid) && i < 500) begin
            @(negedge clk);
            i++;
        end
        chk(name, 64'(sb_q.size()), 64'd0);
    endtask

    task automatic check_outputs_zero(input string tag);
        chk({tag, "_out_valid"}, 64'(out_valid), 64'd0);
        chk({tag, "_out_double"}, out_double, 64'd0);
        chk({tag, "_out_ch"}, 64'(out_ch), 64'd0);
        chk({tag, "_cvt_enable"}, 64'(cvt_enable), 64'd0);
        chk({tag, "_cvt_sig16b"}, 64'(cvt_sig16b), 64'd0);
        chk({tag, "_timeout_err"}, 64'(timeout_err), 64'd0);
        chk({tag, "_overruns"}, 64'({mic_overrun, ref_overrun}), 64'd0);
`ifdef OVR_COUNT_EN
        chk({tag, "_ovr_cnts"}, 64'({mic_ovr_cnt, ref_ovr_cnt}), 64'd0);
`endif
    endtask

    initial begin
        int n;
        int base_mic;
        int base_ref;

        vecs[0] = '{1'b0, 16'h4000, 64'h40E0_0000_0000_0000};
        vecs[1] = '{1'b1, 16'h0001, 64'h4000_0000_0000_0000};
        vecs[2] = '{1'b0, 16'h8001, 64'hC000_0000_0000_0000};
        vecs[3] = '{1'b1, 16'h0003, 64'h4018_0000_0000_0000};
        vecs[4] = '{1'b0, 16'h0000, 64'h0000_0000_0000_0000};
        vecs[5] = '{1'b1, 16'hFFFF, 64'hC0EF_FFC0_0000_0000};

        rst_n      = 1'b0;
        mic_sample = '0;
        ref_sample = '0;
        mic_valid  = 1'b0;
        ref_valid  = 1'b0;
        repeat (3) @(negedge clk);
        check_outputs_zero("reset");
        rst_n = 1'b1;

        // Single conversions with enable latency and one-cycle enable pulse.
        for (int i = 0; i < 6; i++) begin
            send(vecs[i].ch, vecs[i].smp, 1'b0);
            sb_q.push_back(res_t'{vecs[i].ch, vecs[i].dbl});
            chk("enable_early", 64'(cvt_enable), 64'd0);
            @(negedge clk);
            chk("enable_at_t2", 64'(cvt_enable), 64'd1);
            chk("issue_sample", 64'(cvt_sig16b), 64'(vecs[i].smp));
            @(negedge clk);
            chk("enable_pulse", 64'(cvt_enable), 64'd0);
            chk("sample_held", 64'(cvt_sig16b), 64'(vecs[i].smp));
            drain("table_drain");
        end

        // Round-robin: last served ref, tie goes to mic; then last served mic, tie goes to ref.
        ack_en = 1'b0;
        send(1'b1, 16'h0010, 1'b1);
        wait_valid("rr_a_hold");
        send_both(16'h0020, 16'h0030, 1'b0);
        ack_en = 1'b1;
        drain("rr_a_drain");
        ack_en = 1'b0;
        send(1'b0, 16'h0040, 1'b1);
        wait_valid("rr_b_hold");
        send_both(16'h0050, 16'h0060, 1'b1);
        ack_en = 1'b1;
        drain("rr_b_drain");

        // Overrun while the converter result is held: newest ref sample survives.
        base_mic = mic_pulses;
        base_ref = ref_pulses;
        ack_en = 1'b0;
        send(1'b0, 16'h0100, 1'b1);
        wait_valid("ovr_hold");
        send(1'b1, 16'h0201, 1'b0);
        send(1'b1, 16'h0202, 1'b0);
        send(1'b1, 16'h0203, 1'b1);
        repeat (2) @(negedge clk);
        chk("ref_overrun_pulses", 64'(ref_pulses - base_ref), 64'd2);
        chk("mic_overrun_pulses", 64'(mic_pulses - base_mic), 64'd0);
`ifdef OVR_COUNT_EN
        chk("ref_ovr_cnt", 64'(ref_ovr_cnt), 64'(ref_pulses));
        chk("mic_ovr_cnt", 64'(mic_ovr_cnt), 64'(mic_pulses));
`endif
        ack_en = 1'b1;
        drain("ovr_drain");

        // A new sample arriving in the ISSUE cycle is kept without overrun.
        base_mic = mic_pulses;
        send(1'b0, 16'h0301, 1'b1);
        send(1'b0, 16'h0302, 1'b1);
        repeat (2) @(negedge clk);
        chk("issue_take_no_overrun", 64'(mic_pulses - base_mic), 64'd0);
        drain("issue_take_drain");

        // Stale ready from the previous conversion must not be captured.
        stale = 1'b1;
        send(1'b0, 16'h1234, 1'b1);
        drain("stale_drain");
        stale = 1'b0;

        // Timeout: last served mic, so ref is granted, times out and is dropped; mic follows.
        stuck = 1'b1;
        @(negedge clk);
        mic_sample = 16'h0401;
        ref_sample = 16'h0402;
        mic_valid  = 1'b1;
        ref_valid  = 1'b1;
        sb_q.push_back(res_t'{1'b0, conv(16'h0401)});
        @(negedge clk);
        mic_valid = 1'b0;
        ref_valid = 1'b0;
        @(negedge clk);
        chk("to_enable", 64'(cvt_enable), 64'd1);
        chk("to_issue_ref", 64'(cvt_sig16b), 64'h0402);
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!timeout_err && n < 200);
        chk("timeout_latency", 64'(n), 64'(TIMEOUT + 2));
        @(negedge clk);
        chk("timeout_pulse_1cyc", 64'(timeout_err), 64'd0);
        stuck = 1'b0;
        drain("timeout_drain");

        // Reset in the middle of WAIT.
        stuck = 1'b1;
        send(1'b0, 16'h0501, 1'b0);
        repeat (6) @(negedge clk);
        rst_n = 1'b0;
        @(negedge clk);
        check_outputs_zero("midreset");
        rst_n = 1'b1;
        stuck = 1'b0;
        send(1'b1, 16'h0601, 1'b1);
        drain("post_reset_drain");
        repeat (3) @(negedge clk);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
        $finish;
    end

endmodule
